// File: rtl/ovr_sched_pkg.sv
// Shared types and helpers for the override-window scheduler.
// Imported by the arbiter and the top-level sequencer.
package ovr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RELEASE
  } state_t;

  function automatic int idx_w(input int n);
    if ($clog2(n) < 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches upward from ptr and wraps around.
module rr_arbiter
  import ovr_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx
);

  always_comb begin
    int k;
    logic found;
    k = 0;
    found = 1'b0;
    gnt = '0;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (int'(ptr) + i) % N_REQ;
      if (!found && req[k]) begin
        found = 1'b1;
        gnt[k] = 1'b1;
        idx = IW'(k);
      end
    end
  end

endmodule

// File: rtl/ovr_sched.sv
// Override-window sequencer: round-robin grants, timed hold,
// and a mandatory released cycle between windows.
module ovr_sched
  import ovr_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W_DUR = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ-1:0]         i_req_val,
  input  logic [N_REQ*W_DUR-1:0]   i_req_dur,
  input  logic                     i_abort,
  output logic [N_REQ-1:0]         o_gnt,
  output logic                     o_ovr_en,
  output logic                     o_ovr_val,
  output logic [$clog2(N_REQ)-1:0] o_idx,
  output logic                     o_busy
);

  localparam int IW = idx_w(N_REQ);

  state_t           state;
  logic [W_DUR-1:0] cnt;
  logic [IW-1:0]    rr_ptr;

  logic [N_REQ-1:0] win_gnt;
  logic [IW-1:0]    win_idx;
  logic [W_DUR-1:0] win_dur;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req(i_req),
    .ptr(rr_ptr),
    .gnt(win_gnt),
    .idx(win_idx)
  );

  assign win_dur = i_req_dur[int'(win_idx)*W_DUR +: W_DUR];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rr_ptr    <= '0;
      o_gnt     <= '0;
      o_ovr_en  <= 1'b0;
      o_ovr_val <= 1'b0;
      o_idx     <= '0;
      o_busy    <= 1'b0;
    end else begin
      o_gnt <= '0;
      unique case (state)
        IDLE: begin
          if (|i_req) begin
            state     <= HOLD;
            o_gnt     <= win_gnt;
            o_idx     <= win_idx;
            o_ovr_val <= i_req_val[win_idx];
            o_ovr_en  <= 1'b1;
            o_busy    <= 1'b1;
            // zero duration still yields one override cycle
            cnt       <= (win_dur == '0) ? '0 : win_dur - 1'b1;
            rr_ptr    <= (int'(win_idx) == N_REQ - 1) ?
                         '0 : win_idx + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0 || i_abort) begin
            state     <= RELEASE;
            o_ovr_en  <= 1'b0;
            o_ovr_val <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RELEASE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          o_ovr_en  <= 1'b0;
          o_ovr_val <= 1'b0;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ovr_sched.sv
// Self-checking bench for ovr_sched: vector table plus
// scoreboard of expected grants, and reset/abort sequences.
module tb_ovr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  req_val;
  logic [15:0] req_dur;
  logic        abort;
  logic [3:0]  gnt;
  logic        ovr_en;
  logic        ovr_val;
  logic [1:0]  idx;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  ovr_sched #(
    .N_REQ(4),
    .W_DUR(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_req(req),
    .i_req_val(req_val),
    .i_req_dur(req_dur),
    .i_abort(abort),
    .o_gnt(gnt),
    .o_ovr_en(ovr_en),
    .o_ovr_val(ovr_val),
    .o_idx(idx),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  val;
    logic [15:0] dur;
    int          abort_at;
    bit          ab_idle;
    bit          gap;
    logic [3:0]  gnt;
    logic [1:0]  idx;
    logic        ev;
    int          len;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       ev;
    int         len;
  } exp_t;

  vec_t vt[10];
  exp_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int waited;
    int len;
    int c;
    int fall_cyc;

    //          req     val     dur       ab  ai gp gnt     idx ev len
    vt[0] = '{4'b1111, 4'b0000, 16'h1111, 0, 0, 0, 4'b0001, 0, 0, 1};
    vt[1] = '{4'b0010, 4'b0010, 16'h0030, 0, 0, 0, 4'b0010, 1, 1, 3};
    vt[2] = '{4'b1000, 4'b1000, 16'h0000, 0, 0, 0, 4'b1000, 3, 1, 1};
    vt[3] = '{4'b0101, 4'b0001, 16'h0202, 0, 0, 0, 4'b0001, 0, 1, 2};
    vt[4] = '{4'b0100, 4'b0001, 16'h0202, 0, 0, 1, 4'b0100, 2, 0, 2};
    vt[5] = '{4'b1001, 4'b0001, 16'h1111, 0, 0, 0, 4'b1000, 3, 0, 1};
    vt[6] = '{4'b0001, 4'b0001, 16'h1113, 0, 0, 1, 4'b0001, 0, 1, 3};
    vt[7] = '{4'b0100, 4'b0100, 16'h0800, 2, 0, 0, 4'b0100, 2, 1, 2};
    vt[8] = '{4'b0010, 4'b0010, 16'h0020, 0, 1, 0, 4'b0010, 1, 1, 2};
    vt[9] = '{4'b1111, 4'b1111, 16'hFFFF, 0, 0, 0, 4'b0100, 2, 1, 15};

    rst = 1'b1;
    req = 4'b1111;
    req_val = 4'b1111;
    req_dur = 16'hFFFF;
    abort = 1'b0;
    fall_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_outputs", {gnt, ovr_en, ovr_val, idx, busy}, '0);
    end
    rst = 1'b0;

    foreach (vt[v]) begin
      req = vt[v].req;
      req_val = vt[v].val;
      req_dur = vt[v].dur;
      abort = vt[v].ab_idle;
      sb.push_back('{vt[v].gnt, vt[v].idx, vt[v].ev, vt[v].len});
      waited = 0;
      do begin
        tick();
        waited++;
      end while (gnt == '0 && waited < 8);
      chk($sformatf("v%0d_latency", v), waited, 1);
      e = sb.pop_front();
      chk($sformatf("v%0d_gnt", v), gnt, e.gnt);
      chk($sformatf("v%0d_idx", v), idx, e.idx);
      chk($sformatf("v%0d_en", v), ovr_en, 1);
      if (vt[v].gap)
        chk($sformatf("v%0d_gap", v), cyc - fall_cyc, 2);
      // change inputs after grant: window must use latched values
      req = req & ~gnt;
      req_val = '0;
      req_dur = '0;
      c = 1;
      len = 0;
      while (ovr_en && c < 40) begin
        len++;
        chk($sformatf("v%0d_val", v), ovr_val, e.ev);
        abort = (c == vt[v].abort_at);
        tick();
        c++;
        if (ovr_en)
          chk($sformatf("v%0d_gnt_pulse", v), gnt, 0);
      end
      abort = 1'b0;
      fall_cyc = cyc;
      chk($sformatf("v%0d_len", v), len, e.len);
      chk($sformatf("v%0d_release", v),
          {busy, ovr_val, gnt}, {1'b1, 1'b0, 4'b0000});
      tick();
      chk($sformatf("v%0d_idle", v), {busy, ovr_en}, 2'b00);
    end
    chk("sb_empty", sb.size(), 0);

    req = 4'b0001;
    req_val = 4'b0001;
    req_dur = 16'h0008;
    tick();
    chk("rstmid_gnt", gnt, 4'b0001);
    req = 4'b0000;
    for (int i = 0; i < 3; i++) tick();
    chk("rstmid_hold4", {busy, ovr_en, ovr_val}, 3'b111);
    rst = 1'b1;
    tick();
    chk("rstmid_drop", {gnt, ovr_en, ovr_val, idx, busy}, '0);
    rst = 1'b0;
    req = 4'b0011;
    tick();
    chk("rstmid_ptr", gnt, 4'b0001);
    chk("rstmid_en", ovr_en, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
